// File: rtl/ovi_wb_pkg.sv
// Shared Wishbone B4 types for the memory-backed slave: cycle/burst type
// encodings, FSM states and the burst next-address rule.
package ovi_wb_pkg;

   typedef enum logic [2:0] {
      CTI_CLASSIC = 3'b000,
      CTI_CONST   = 3'b001,
      CTI_INCR    = 3'b010,
      CTI_END     = 3'b111
   } cti_e;

   typedef enum logic [1:0] {
      BTE_LINEAR = 2'b00,
      BTE_WRAP4  = 2'b01,
      BTE_WRAP8  = 2'b10,
      BTE_WRAP16 = 2'b11
   } bte_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_TERM,
      ST_BURST
   } state_e;

   localparam int unsigned WADR_W = 32;
   typedef logic [WADR_W-1:0] wadr_t;

   // Word address of the following beat; wrap bursts only step the low bits.
   function automatic wadr_t next_burst_addr(input wadr_t addr, input logic [2:0] cti,
                                             input logic [1:0] bte);
      wadr_t nxt;
      nxt = addr;
      if (cti == CTI_INCR) begin
         case (bte)
            BTE_LINEAR: nxt      = addr + WADR_W'(1);
            BTE_WRAP4:  nxt[1:0] = addr[1:0] + 2'd1;
            BTE_WRAP8:  nxt[2:0] = addr[2:0] + 3'd1;
            default:    nxt[3:0] = addr[3:0] + 4'd1;
         endcase
      end
      return nxt;
   endfunction

endpackage

// File: rtl/ovi_wb_burst_addr.sv
// Holds the current word address and a precomputed next-beat address so the
// RAM can be prefetched one beat ahead without a combinational wrap adder.
module ovi_wb_burst_addr
   import ovi_wb_pkg::*;
#(
   parameter int unsigned AW = 8
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          load_i,
   input  logic [AW-1:0] load_adr_i,
   input  logic          adv_i,
   input  logic [2:0]    cti_i,
   input  logic [1:0]    bte_i,
   output logic [AW-1:0] adr_o,
   output logic [AW-1:0] nxt_adr_o
);

   logic [AW-1:0] adr_q, adr_d;
   logic [AW-1:0] nxt_q, nxt_d;

   always_comb begin
      adr_d = adr_q;
      nxt_d = nxt_q;
      if (load_i) begin
         adr_d = load_adr_i;
         nxt_d = AW'(next_burst_addr(wadr_t'(load_adr_i), cti_i, bte_i));
      end else if (adv_i) begin
         adr_d = nxt_q;
         nxt_d = AW'(next_burst_addr(wadr_t'(nxt_q), cti_i, bte_i));
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         adr_q <= '0;
         nxt_q <= '0;
      end else begin
         adr_q <= adr_d;
         nxt_q <= nxt_d;
      end
   end

   assign adr_o     = adr_q;
   assign nxt_adr_o = nxt_q;

endmodule

// File: rtl/ovi_wb_mem_slave.sv
// Wishbone B4 slave over an on-chip word RAM: classic and registered-feedback
// bursts, programmable first-ack latency, address-range error and forced retry.
module ovi_wb_mem_slave
   import ovi_wb_pkg::*;
#(
   parameter int unsigned WB_ADDR_W = 32,
   parameter int unsigned WB_DATA_W = 32,
   parameter int unsigned MEM_DEPTH = 256
) (
   input  logic                   wb_clk,
   input  logic                   wb_resetn,
   input  logic [WB_ADDR_W-1:0]   wb_adr_i,
   input  logic [WB_DATA_W-1:0]   wb_dat_i,
   input  logic [WB_DATA_W/8-1:0] wb_sel_i,
   input  logic                   wb_we_i,
   input  logic                   wb_cyc_i,
   input  logic                   wb_stb_i,
   input  logic [2:0]             wb_cti_i,
   input  logic [1:0]             wb_bte_i,
   output logic [WB_DATA_W-1:0]   wb_dat_o,
   output logic                   wb_ack_o,
   output logic                   wb_err_o,
   output logic                   wb_rty_o,
   input  logic [7:0]             cfg_ack_dly,
   input  logic                   cfg_rty_en
);

   localparam int unsigned AW    = $clog2(MEM_DEPTH);
   localparam int unsigned SEL_W = WB_DATA_W / 8;

   state_e               state_q, state_d;
   logic [7:0]           cnt_q, cnt_d;
   logic                 rty_q, rty_d;
   logic [2:0]           cti_q, cti_d;
   logic [1:0]           bte_q, bte_d;
   logic [WB_DATA_W-1:0] dat_q, dat_d;

   logic                 ack_c, err_c, rty_c, load_c, adv_c;
   logic                 in_range_c, burst_end_c, wr_en_c, dat_en_c;
   logic [2:0]           cti_sel_c;
   logic [1:0]           bte_sel_c;
   logic [AW-1:0]        adr_w, nxt_adr_w, rd_idx_c;
   logic [WB_DATA_W-1:0] merged_c;
   logic [WB_DATA_W-1:0] mem [MEM_DEPTH];

   assign in_range_c  = (wb_adr_i >> (AW + 2)) == '0;
   assign burst_end_c = (wb_cti_i == CTI_END) || (wb_cti_i == CTI_CLASSIC);

   // Terminations decode from registered state and are gated by stb, so a
   // master wait state inside a burst never sees a stray ack.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rty_d   = rty_q;
      cti_d   = cti_q;
      bte_d   = bte_q;
      ack_c   = 1'b0;
      err_c   = 1'b0;
      rty_c   = 1'b0;
      load_c  = 1'b0;
      adv_c   = 1'b0;
      if (!wb_cyc_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (wb_stb_i) begin
               load_c  = 1'b1;
               cnt_d   = cfg_ack_dly;
               rty_d   = cfg_rty_en;
               cti_d   = wb_cti_i;
               bte_d   = wb_bte_i;
               state_d = (cfg_ack_dly != 8'd0) ? ST_WAIT : ST_TERM;
            end
            ST_WAIT: begin
               cnt_d = cnt_q - 8'd1;
               if (cnt_q == 8'd1) state_d = ST_TERM;
            end
            ST_TERM: if (wb_stb_i) begin
               state_d = ST_IDLE;
               if (rty_q) begin
                  rty_c = 1'b1;
               end else if (!in_range_c) begin
                  err_c = 1'b1;
               end else begin
                  ack_c = 1'b1;
                  if ((cti_q == CTI_CONST) || (cti_q == CTI_INCR)) begin
                     state_d = ST_BURST;
                     adv_c   = 1'b1;
                  end
               end
            end
            ST_BURST: if (wb_stb_i) begin
               if (!in_range_c) begin
                  err_c   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  ack_c = 1'b1;
                  if (burst_end_c) state_d = ST_IDLE;
                  else             adv_c   = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge wb_clk or negedge wb_resetn) begin
      if (!wb_resetn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rty_q   <= 1'b0;
         cti_q   <= '0;
         bte_q   <= '0;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rty_q   <= rty_d;
         cti_q   <= cti_d;
         bte_q   <= bte_d;
         if (dat_en_c) dat_q <= dat_d;
      end
   end

   assign cti_sel_c = load_c ? wb_cti_i : cti_q;
   assign bte_sel_c = load_c ? wb_bte_i : bte_q;

   ovi_wb_burst_addr #(.AW(AW)) u_burst_addr (
      .clk_i      (wb_clk),
      .rst_n_i    (wb_resetn),
      .load_i     (load_c),
      .load_adr_i (AW'(wb_adr_i >> 2)),
      .adv_i      (adv_c),
      .cti_i      (cti_sel_c),
      .bte_i      (bte_sel_c),
      .adr_o      (adr_w),
      .nxt_adr_o  (nxt_adr_w)
   );

   // dat_q always mirrors the current word, so it doubles as the old value
   // for the byte-lane bypass when a const burst reads back what it just wrote.
   always_comb begin
      merged_c = dat_q;
      for (int unsigned b = 0; b < SEL_W; b++) begin
         if (wb_sel_i[b]) merged_c[8*b +: 8] = wb_dat_i[8*b +: 8];
      end
   end

   assign wr_en_c  = ack_c & wb_we_i;
   assign dat_en_c = load_c | adv_c;
   assign rd_idx_c = load_c ? AW'(wb_adr_i >> 2) : (adv_c ? nxt_adr_w : adr_w);
   assign dat_d    = (wr_en_c && (rd_idx_c == adr_w)) ? merged_c : mem[rd_idx_c];

   always_ff @(posedge wb_clk) begin
      if (wr_en_c) begin
         for (int unsigned b = 0; b < SEL_W; b++) begin
            if (wb_sel_i[b]) mem[adr_w][8*b +: 8] <= wb_dat_i[8*b +: 8];
         end
      end
   end

   assign wb_dat_o = dat_q;
   assign wb_ack_o = ack_c;
   assign wb_err_o = err_c;
   assign wb_rty_o = rty_c;

endmodule
